// File: rtl/echo_request_mux_if.sv
// ----------------------------------------------------------------------------
// echo_request_mux_if
//   Bundles the request-side and pipe-side handshakes of echo_request_mux.
//
//   Request side (one lane per channel, NUM_CH lanes):
//     chan_enq_ena   per-channel enqueue strobe
//     chan_enq_meth  per-channel 32-bit method word, channel i at [32*i +: 32]
//     chan_enq_v     per-channel payload, channel i at [DATA_W*i +: DATA_W]
//     chan_enq_rdy   per-channel ready
//   Pipe side (single outbound lane):
//     pipe_enq_ena   outbound message valid
//     pipe_enq_v     {v, meth, tag}, tag in bits [31:0]
//     pipe_enq_rdy   outbound sink ready
//
//   Modports:
//     master  the mux itself (consumes request lanes, drives the pipe)
//     slave   the environment (drives request lanes, sinks the pipe)
// ----------------------------------------------------------------------------
interface echo_request_mux_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32
);
    logic [NUM_CH-1:0]        chan_enq_ena;
    logic [NUM_CH*32-1:0]     chan_enq_meth;
    logic [NUM_CH*DATA_W-1:0] chan_enq_v;
    logic [NUM_CH-1:0]        chan_enq_rdy;
    logic                     pipe_enq_ena;
    logic [DATA_W+63:0]       pipe_enq_v;
    logic                     pipe_enq_rdy;

    modport master (
        input  chan_enq_ena,
        input  chan_enq_meth,
        input  chan_enq_v,
        output chan_enq_rdy,
        output pipe_enq_ena,
        output pipe_enq_v,
        input  pipe_enq_rdy
    );

    modport slave (
        output chan_enq_ena,
        output chan_enq_meth,
        output chan_enq_v,
        input  chan_enq_rdy,
        input  pipe_enq_ena,
        input  pipe_enq_v,
        output pipe_enq_rdy
    );
endinterface

// File: rtl/echo_request_mux.sv
// ----------------------------------------------------------------------------
// echo_request_mux
//   Round-robin merges NUM_CH tagged request channels onto one outbound pipe.
//   Each channel owns a single holding slot; a shared output register drives
//   the pipe. Channel i is tagged TAG_BASE+i (mod 2^32) in bits [31:0] of the
//   outbound word {v, meth, tag}.
//
//   Ports:
//     CLK        clock, all state updates on posedge
//     nRST       synchronous active-low reset
//     bus        echo_request_mux_if.master (request lanes in, pipe out)
//     msg_count  32-bit count of delivered messages (ECHO_REQ_STATS_EN only)
//
//   Configuration macro:
//     ECHO_REQ_STATS_EN  adds the msg_count port and its wrapping counter.
//
//   Timing: a beat accepted in cycle t sits in its slot in t+1 and is on the
//   pipe in t+2. A slot that is being drained accepts a new beat in the same
//   cycle, so a single channel can stream one message per cycle.
// ----------------------------------------------------------------------------
module echo_request_mux #(
    parameter int          NUM_CH   = 4,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] TAG_BASE = 32'd1
) (
    input  logic               CLK,
    input  logic               nRST,
    echo_request_mux_if.master bus
`ifdef ECHO_REQ_STATS_EN
    ,
    output logic [31:0]        msg_count
`endif
);
    localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int OUT_W = DATA_W + 64;

    // Per-channel holding slots
    logic [NUM_CH-1:0] held_q, held_d;
    logic [31:0]       meth_q [NUM_CH];
    logic [DATA_W-1:0] v_q    [NUM_CH];

    // Output register and arbiter pointer
    logic              out_valid_q, out_valid_d;
    logic [OUT_W-1:0]  out_data_q, out_data_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic [PTR_W-1:0]  grant;
    logic              any_held;
    logic              out_load;
    logic [NUM_CH-1:0] drain;
    logic [NUM_CH-1:0] accept;

    // (base + step) mod NUM_CH, for step < NUM_CH
    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int step);
        int sum;
        sum = int'(base) + step;
        if (sum >= NUM_CH) begin
            sum = sum - NUM_CH;
        end
        return sum[PTR_W-1:0];
    endfunction

    // The output register can take a new word when empty or when the sink
    // is consuming the current one this cycle.
    assign out_load = !out_valid_q || bus.pipe_enq_rdy;

    // Round-robin arbiter: first held slot at or after rr_ptr, wrapping.
    always_comb begin
        logic [PTR_W-1:0] idx;
        // NOTE: every always_comb output gets a default before any branch so
        // no path leaves it unassigned; otherwise a latch is inferred.
        any_held = 1'b0;
        grant    = '0;
        idx      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            idx = wrap_idx(rr_ptr_q, k);
            if (!any_held && held_q[idx]) begin
                any_held = 1'b1;
                grant    = idx;
            end
        end
    end

    // One-hot of the slot emptied into the output register this cycle.
    always_comb begin
        drain = '0;
        if (out_load && any_held) begin
            drain[grant] = 1'b1;
        end
    end

    // Ready depends only on state, pipe ready and reset, never on any ENA.
    assign bus.chan_enq_rdy = {NUM_CH{nRST}} & (~held_q | drain);
    assign accept           = bus.chan_enq_ena & bus.chan_enq_rdy;

    // A same-cycle refill wins over the drain, keeping the slot full.
    assign held_d = (held_q & ~drain) | accept;

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        if (out_load) begin
            out_valid_d = any_held;
            if (any_held) begin
                out_data_d = {v_q[grant], meth_q[grant], TAG_BASE + 32'(grant)};
                rr_ptr_d   = wrap_idx(grant, 1);
            end
        end
    end

    // Control state: reset clears all occupancy, discarding in-flight data.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!nRST) begin
            held_q      <= '0;
            out_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            held_q      <= held_d;
            out_valid_q <= out_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; it is only observed
    // behind held_q / out_valid_q, which are.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (accept[i]) begin
                meth_q[i] <= bus.chan_enq_meth[32*i +: 32];
                v_q[i]    <= bus.chan_enq_v[DATA_W*i +: DATA_W];
            end
        end
        out_data_q <= out_data_d;
    end

    assign bus.pipe_enq_ena = out_valid_q;
    assign bus.pipe_enq_v   = out_data_q;

`ifdef ECHO_REQ_STATS_EN
    logic [31:0] msg_count_q, msg_count_d;

    // Counts pipe transfers; wraps naturally from all-ones to zero.
    assign msg_count_d = msg_count_q + {31'd0, out_valid_q && bus.pipe_enq_rdy};

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            msg_count_q <= '0;
        end else begin
            msg_count_q <= msg_count_d;
        end
    end

    assign msg_count = msg_count_q;
`endif

endmodule

// File: tb/tb_echo_request_mux.sv
// ----------------------------------------------------------------------------
// tb_echo_request_mux
//   Directed scenarios followed by a randomized phase. A per-channel queue of
//   accepted-but-undelivered messages serves as the reference: any beat shown
//   on the pipe must be the oldest pending message of the channel its tag
//   names, and a channel with nothing pending must be ready.
// ----------------------------------------------------------------------------
module tb_echo_request_mux;
    localparam int          NUM_CH   = 4;
    localparam int          DATA_W   = 32;
    localparam logic [31:0] TAG_BASE = 32'd1;
    localparam int          OUT_W    = DATA_W + 64;

    typedef struct packed {
        logic [31:0]       meth;
        logic [DATA_W-1:0] v;
    } msg_t;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    echo_request_mux_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

`ifdef ECHO_REQ_STATS_EN
    logic [31:0] msg_count;
`endif

    echo_request_mux #(
        .NUM_CH  (NUM_CH),
        .DATA_W  (DATA_W),
        .TAG_BASE(TAG_BASE)
    ) dut (
        .CLK (CLK),
        .nRST(nRST),
        .bus (bus)
`ifdef ECHO_REQ_STATS_EN
        ,
        .msg_count(msg_count)
`endif
    );

    msg_t sb_q [NUM_CH][$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive_chan(input int ch, input logic [31:0] meth, input logic [DATA_W-1:0] v);
        bus.chan_enq_ena[ch]                = 1'b1;
        bus.chan_enq_meth[32*ch +: 32]      = meth;
        bus.chan_enq_v[DATA_W*ch +: DATA_W] = v;
    endtask

    // Lets combinational outputs settle, then checks the pipe against the
    // reference and records this cycle's deliveries and accepts.
    task automatic settle_and_record();
        logic [31:0] ch;
        msg_t        m;
        #1;
        if (!nRST) begin
            for (int i = 0; i < NUM_CH; i++) sb_q[i].delete();
            return;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (sb_q[i].size() == 0) check("idle_rdy", 128'(bus.chan_enq_rdy[i]), 128'(1));
        end
        if (bus.pipe_enq_ena) begin
            ch = bus.pipe_enq_v[31:0] - TAG_BASE;
            check("tag_range", 128'(ch < 32'(NUM_CH)), 128'(1));
            if (ch < 32'(NUM_CH)) begin
                check("sb_pending", 128'(sb_q[ch].size() != 0), 128'(1));
                if (sb_q[ch].size() != 0) begin
                    m = sb_q[ch][0];
                    check("sb_beat", 128'(bus.pipe_enq_v[OUT_W-1:32]), 128'({m.v, m.meth}));
                    if (bus.pipe_enq_rdy) void'(sb_q[ch].pop_front());
                end
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.chan_enq_ena[i] && bus.chan_enq_rdy[i]) begin
                m.meth = bus.chan_enq_meth[32*i +: 32];
                m.v    = bus.chan_enq_v[DATA_W*i +: DATA_W];
                sb_q[i].push_back(m);
            end
        end
    endtask

    task automatic cycle();
        settle_and_record();
        tick();
    endtask

    task automatic do_reset(input int cycles);
        bus.chan_enq_ena = '0;
        nRST = 1'b0;
        for (int i = 0; i < cycles; i++) cycle();
        nRST = 1'b1;
    endtask

    initial begin
        logic [OUT_W-1:0] exp_word;
        bit               empty;

        nRST              = 1'b0;
        bus.chan_enq_ena  = '0;
        bus.chan_enq_meth = '0;
        bus.chan_enq_v    = '0;
        bus.pipe_enq_rdy  = 1'b0;
        tick();
        tick();

        // Reset state
        settle_and_record();
        check("rst_rdy", 128'(bus.chan_enq_rdy), 128'(0));
        check("rst_ena", 128'(bus.pipe_enq_ena), 128'(0));
        tick();
        nRST = 1'b1;
        settle_and_record();
        check("post_rst_rdy", 128'(bus.chan_enq_rdy), 128'(4'hF));
        tick();

        // Single message on ch2: two-cycle latency, exactly one beat
        bus.pipe_enq_rdy = 1'b1;
        drive_chan(2, 32'd5, 32'hCAFE);
        cycle();
        bus.chan_enq_ena = '0;
        settle_and_record();
        check("t1_lat_t1", 128'(bus.pipe_enq_ena), 128'(0));
        tick();
        settle_and_record();
        check("t1_ena", 128'(bus.pipe_enq_ena), 128'(1));
        check("t1_word", 128'(bus.pipe_enq_v), 128'({32'hCAFE, 32'd5, 32'd3}));
        tick();
        settle_and_record();
        check("t1_once", 128'(bus.pipe_enq_ena), 128'(0));
        tick();

        // All channels at once from rr_ptr = 0
        do_reset(2);
        bus.pipe_enq_rdy = 1'b1;
        for (int i = 0; i < NUM_CH; i++) drive_chan(i, 32'd10 + 32'(i), 32'h200 + 32'(i));
        cycle();
        bus.chan_enq_ena = '0;
        settle_and_record();
        check("t2_lat", 128'(bus.pipe_enq_ena), 128'(0));
        tick();
        for (int k = 0; k < NUM_CH; k++) begin
            settle_and_record();
            check("t2_ena", 128'(bus.pipe_enq_ena), 128'(1));
            check("t2_tag", 128'(bus.pipe_enq_v[31:0]), 128'(TAG_BASE + 32'(k)));
            tick();
        end
        settle_and_record();
        check("t2_idle", 128'(bus.pipe_enq_ena), 128'(0));
        tick();
        // Pointer back at 0: ch0 must beat ch3
        drive_chan(0, 32'h20, 32'h300);
        drive_chan(3, 32'h23, 32'h303);
        cycle();
        bus.chan_enq_ena = '0;
        cycle();
        settle_and_record();
        check("t2_rr_first", 128'(bus.pipe_enq_v[31:0]), 128'(TAG_BASE));
        tick();
        settle_and_record();
        check("t2_rr_second", 128'(bus.pipe_enq_v[31:0]), 128'(TAG_BASE + 32'd3));
        tick();

        // Backpressure: sink low for 10 cycles, ch0 parks two messages
        bus.pipe_enq_rdy = 1'b0;
        drive_chan(0, 32'h30, 32'hA0);
        cycle();
        drive_chan(0, 32'h31, 32'hA1);
        settle_and_record();
        check("t3_second_rdy", 128'(bus.chan_enq_rdy[0]), 128'(1));
        tick();
        bus.chan_enq_ena = '0;
        exp_word = {32'hA0, 32'h30, TAG_BASE};
        for (int w = 2; w < 10; w++) begin
            settle_and_record();
            check("t3_full_rdy", 128'(bus.chan_enq_rdy[0]), 128'(0));
            check("t3_frozen_ena", 128'(bus.pipe_enq_ena), 128'(1));
            check("t3_frozen_word", 128'(bus.pipe_enq_v), 128'(exp_word));
            tick();
        end
        bus.pipe_enq_rdy = 1'b1;
        settle_and_record();
        check("t3_rel_first", 128'(bus.pipe_enq_v), 128'(exp_word));
        tick();
        settle_and_record();
        check("t3_rel_second", 128'(bus.pipe_enq_v), 128'({32'hA1, 32'h31, TAG_BASE}));
        check("t3_ena2", 128'(bus.pipe_enq_ena), 128'(1));
        tick();
        settle_and_record();
        check("t3_no_dup", 128'(bus.pipe_enq_ena), 128'(0));
        tick();

        // ch1 streams 8 beats back to back
        for (int w = 0; w < 10; w++) begin
            bus.chan_enq_ena = '0;
            if (w < 8) drive_chan(1, 32'h40 + 32'(w), 32'h100 + 32'(w));
            settle_and_record();
            if (w < 8) check("t4_rdy", 128'(bus.chan_enq_rdy[1]), 128'(1));
            if (w >= 2) begin
                check("t4_ena", 128'(bus.pipe_enq_ena), 128'(1));
                check("t4_word", 128'(bus.pipe_enq_v),
                      128'({32'h100 + 32'(w - 2), 32'h40 + 32'(w - 2), TAG_BASE + 32'd1}));
            end
            tick();
        end
        bus.chan_enq_ena = '0;
        settle_and_record();
        check("t4_end", 128'(bus.pipe_enq_ena), 128'(0));
        tick();

        // Reset with the output register and two slots occupied
        bus.pipe_enq_rdy = 1'b0;
        drive_chan(0, 32'h50, 32'hB0);
        drive_chan(2, 32'h52, 32'hB2);
        cycle();
        bus.chan_enq_ena = '0;
        drive_chan(2, 32'h53, 32'hB3);
        settle_and_record();
        check("t5_refill_rdy", 128'(bus.chan_enq_rdy[2]), 128'(1));
        tick();
        bus.chan_enq_ena = '0;
        nRST = 1'b0;
        settle_and_record();
        check("t5_rst_rdy", 128'(bus.chan_enq_rdy), 128'(0));
        tick();
        settle_and_record();
        check("t5_rst_rdy2", 128'(bus.chan_enq_rdy), 128'(0));
        check("t5_rst_ena", 128'(bus.pipe_enq_ena), 128'(0));
        tick();
        nRST = 1'b1;
        bus.pipe_enq_rdy = 1'b1;
        for (int w = 0; w < 4; w++) begin
            settle_and_record();
            check("t5_no_stale", 128'(bus.pipe_enq_ena), 128'(0));
            tick();
        end
`ifdef ECHO_REQ_STATS_EN
        check("t5_cnt_zero", 128'(msg_count), 128'(0));

        // Counter: three deliveries, then wrap from all-ones
        for (int w = 0; w < 3; w++) begin
            bus.chan_enq_ena = '0;
            drive_chan(0, 32'h60 + 32'(w), 32'hC0 + 32'(w));
            cycle();
        end
        bus.chan_enq_ena = '0;
        for (int w = 0; w < 4; w++) cycle();
        check("t6_cnt_three", 128'(msg_count), 128'(3));
        bus.pipe_enq_rdy = 1'b0;
        drive_chan(0, 32'h70, 32'hD0);
        cycle();
        bus.chan_enq_ena = '0;
        cycle();
        cycle();
        force dut.msg_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.msg_count_q;
        settle_and_record();
        check("t6_cnt_forced", 128'(msg_count), 128'(32'hFFFF_FFFF));
        tick();
        bus.pipe_enq_rdy = 1'b1;
        settle_and_record();
        check("t6_cnt_hold", 128'(msg_count), 128'(32'hFFFF_FFFF));
        tick();
        settle_and_record();
        check("t6_cnt_wrap", 128'(msg_count), 128'(0));
        tick();
`endif

        // Randomized traffic with random sink backpressure
        for (int c = 0; c < 400; c++) begin
            bus.chan_enq_ena = '0;
            bus.pipe_enq_rdy = ($urandom_range(0, 3) != 0);
            #1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.chan_enq_rdy[i] && ($urandom_range(0, 1) == 1)) drive_chan(i, $urandom, $urandom);
            end
            cycle();
        end

        // Drain with a bounded wait
        bus.chan_enq_ena = '0;
        bus.pipe_enq_rdy = 1'b1;
        for (int c = 0; c < 20; c++) cycle();
        settle_and_record();
        check("drain_idle", 128'(bus.pipe_enq_ena), 128'(0));
        empty = 1'b1;
        for (int i = 0; i < NUM_CH; i++) if (sb_q[i].size() != 0) empty = 1'b0;
        check("drain_empty", 128'(empty), 128'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
